reg_file_mp: RTL and testbench

- Parametrised multi-port integer register file with an integrated pending-write scoreboard.
- Successor to the single-write, dual-read `reg_file`; sits in the decode/writeback path of the core.
- Generalises width, depth and read/write port counts, adds same-cycle write-to-read bypass, and tracks in-flight producers so issue logic can detect RAW hazards.

---
 rtl/reg_file_mp.sv | 138 +++++++++++++
 tb/tb_reg_file_mp.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with same-cycle write forwarding and a
// per-register pending-producer scoreboard for RAW hazard detection.

module rf_rd_port #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                           rst_n_i,
    input  logic [AW-1:0]                  addr_i,
    input  logic [NREGS-1:0][XLEN-1:0]     regs_i,
    input  logic [NREGS-1:0]               busy_i,
    input  logic [NWR-1:0]                 wr_en_i,
    input  logic [NWR-1:0][AW-1:0]         wr_addr_i,
    input  logic [NWR-1:0][XLEN-1:0]       wr_data_i,
    output logic [XLEN-1:0]                data_o,
    output logic                           busy_o
);
    logic            fwd;
    logic [XLEN-1:0] fwd_data;

    // Later ports overwrite earlier matches, so the highest index wins.
    // Forwarding is gated by reset so outputs read as zero while it is held.
    always_comb begin
        fwd      = 1'b0;
        fwd_data = '0;
        if (BYPASS != 0) begin
            for (int w = 0; w < NWR; w++) begin
                if (rst_n_i && wr_en_i[w] && wr_addr_i[w] == addr_i && addr_i != '0) begin
                    fwd      = 1'b1;
                    fwd_data = wr_data_i[w];
                end
            end
        end
    end

    always_comb begin
        data_o = '0;
        if (addr_i != '0)
            data_o = fwd ? fwd_data : regs_i[addr_i];
        busy_o = busy_i[addr_i] & ~fwd;
    end
endmodule

module reg_file_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*AW-1:0]     wr_addr,
    input  logic [NWR*XLEN-1:0]   wr_data,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  alloc_en,
    input  logic [AW-1:0]         alloc_addr,
    input  logic                  flush,
    output logic [NREGS-1:0]      busy_vec,
    output logic                  wr_conflict
);
    logic [NWR-1:0][AW-1:0]     wa;
    logic [NWR-1:0][XLEN-1:0]   wd;
    logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREGS-1:0]           busy_q, busy_d;
    logic                       conflict_q, conflict_d;

    assign wa = wr_addr;
    assign wd = wr_data;

    always_comb begin
        regs_d = regs_q;
        for (int w = 0; w < NWR; w++)
            if (wr_en[w] && wa[w] != '0)
                regs_d[wa[w]] = wd[w];
    end

    // Priority low to high: write clears, alloc sets (a new producer
    // supersedes the completing one), flush clears everything.
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < NWR; w++)
            if (wr_en[w] && wa[w] != '0)
                busy_d[wa[w]] = 1'b0;
        if (alloc_en && alloc_addr != '0)
            busy_d[alloc_addr] = 1'b1;
        if (flush)
            busy_d = '0;
    end

    generate
        if (NWR == 2) begin : g_conf
            assign conflict_d = wr_en[0] & wr_en[1] & (wa[0] == wa[1]) & (wa[0] != '0);
        end else begin : g_noconf
            assign conflict_d = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_q     <= '0;
            busy_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    assign busy_vec    = busy_q;
    assign wr_conflict = conflict_q;

    generate
        for (genvar i = 0; i < NRD; i++) begin : g_rd
            rf_rd_port #(
                .XLEN(XLEN), .NREGS(NREGS), .NWR(NWR), .BYPASS(BYPASS), .AW(AW)
            ) u_rd (
                .rst_n_i   (reset),
                .addr_i    (rd_addr[i*AW +: AW]),
                .regs_i    (regs_q),
                .busy_i    (busy_q),
                .wr_en_i   (wr_en),
                .wr_addr_i (wa),
                .wr_data_i (wd),
                .data_o    (rd_data[i*XLEN +: XLEN]),
                .busy_o    (rd_busy[i])
            );
        end
    endgenerate
endmodule

// File: tb/tb_reg_file_mp.sv
// Table-driven bench: one forwarding and one non-forwarding instance share stimulus.

module tb_reg_file_mp;
    logic        clk, reset;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [9:0]  rd_addr;
    logic        alloc_en, flush;
    logic [4:0]  alloc_addr;
    logic [63:0] rd_data_b, rd_data_n;
    logic [1:0]  rd_busy_b, rd_busy_n;
    logic [31:0] busy_vec_b, busy_vec_n;
    logic        conf_b, conf_n;

    int total = 0;
    int bad   = 0;

    reg_file_mp #(.BYPASS(1)) dut_b (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush),
        .busy_vec(busy_vec_b), .wr_conflict(conf_b)
    );

    reg_file_mp #(.BYPASS(0)) dut_n (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush),
        .busy_vec(busy_vec_n), .wr_conflict(conf_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        ae;
        logic [4:0]  aa;
        logic        fl;
        logic [4:0]  ra0, ra1;
        logic [31:0] e0, e1;   // forwarding instance read data
        logic [31:0] n0, n1;   // non-forwarding instance read data
        logic [1:0]  eb, nb;   // rd_busy {port1,port0}
        logic [31:0] ebv;
        logic        ec;
    } vec_t;

    vec_t tv[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        wr_en      = t.we;
        wr_addr    = {t.wa1, t.wa0};
        wr_data    = {t.wd1, t.wd0};
        alloc_en   = t.ae;
        alloc_addr = t.aa;
        flush      = t.fl;
        rd_addr    = {t.ra1, t.ra0};
    endtask

    task automatic idle(input logic [4:0] a0, input logic [4:0] a1);
        wr_en = 2'b00; wr_addr = '0; wr_data = '0;
        alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
        rd_addr = {a1, a0};
    endtask

    initial begin
        //        we     wa0   wd0           wa1    wd1           ae    aa     fl    ra0    ra1    e0            e1            n0            n1            eb     nb     ebv           ec
        tv[0]  = '{2'b11, 5'd0, 32'h12345678, 5'd0,  32'h12345678, 1'b0, 5'd0, 1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        2'b00, 2'b00, 32'h0,        1'b0};
        tv[1]  = '{2'b00, 5'd0, 32'h0,        5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        2'b00, 2'b00, 32'h0,        1'b0};
        tv[2]  = '{2'b11, 5'd5, 32'hDEADBEEF, 5'd10, 32'hCAFEBABE, 1'b0, 5'd0, 1'b0, 5'd5,  5'd10, 32'hDEADBEEF, 32'hCAFEBABE, 32'h0,        32'h0,        2'b00, 2'b00, 32'h0,        1'b0};
        tv[3]  = '{2'b00, 5'd0, 32'h0,        5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 5'd5,  5'd10, 32'hDEADBEEF, 32'hCAFEBABE, 32'hDEADBEEF, 32'hCAFEBABE, 2'b00, 2'b00, 32'h0,        1'b0};
        tv[4]  = '{2'b11, 5'd7, 32'hAAAA0000, 5'd7,  32'h5555FFFF, 1'b0, 5'd0, 1'b0, 5'd7,  5'd7,  32'h5555FFFF, 32'h5555FFFF, 32'h0,        32'h0,        2'b00, 2'b00, 32'h0,        1'b0};
        tv[5]  = '{2'b00, 5'd0, 32'h0,        5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 5'd7,  5'd5,  32'h5555FFFF, 32'hDEADBEEF, 32'h5555FFFF, 32'hDEADBEEF, 2'b00, 2'b00, 32'h0,        1'b1};
        tv[6]  = '{2'b00, 5'd0, 32'h0,        5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 5'd7,  5'd10, 32'h5555FFFF, 32'hCAFEBABE, 32'h5555FFFF, 32'hCAFEBABE, 2'b00, 2'b00, 32'h0,        1'b0};
        tv[7]  = '{2'b01, 5'd3, 32'h0000BEEF, 5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 5'd3,  5'd3,  32'h0000BEEF, 32'h0000BEEF, 32'h0,        32'h0,        2'b00, 2'b00, 32'h0,        1'b0};
        tv[8]  = '{2'b00, 5'd0, 32'h0,        5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 5'd3,  5'd0,  32'h0000BEEF, 32'h0,        32'h0000BEEF, 32'h0,        2'b00, 2'b00, 32'h0,        1'b0};
        tv[9]  = '{2'b00, 5'd0, 32'h0,        5'd0,  32'h0,        1'b1, 5'd9, 1'b0, 5'd9,  5'd5,  32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 2'b00, 2'b00, 32'h0,        1'b0};
        tv[10] = '{2'b10, 5'd0, 32'h0,        5'd9,  32'h11111111, 1'b1, 5'd9, 1'b0, 5'd9,  5'd9,  32'h11111111, 32'h11111111, 32'h0,        32'h0,        2'b00, 2'b11, 32'h00000200, 1'b0};
        tv[11] = '{2'b00, 5'd0, 32'h0,        5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 5'd9,  5'd4,  32'h11111111, 32'h0,        32'h11111111, 32'h0,        2'b01, 2'b01, 32'h00000200, 1'b0};
        tv[12] = '{2'b01, 5'd9, 32'h22222222, 5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 5'd9,  5'd9,  32'h22222222, 32'h22222222, 32'h11111111, 32'h11111111, 2'b00, 2'b11, 32'h00000200, 1'b0};
        tv[13] = '{2'b00, 5'd0, 32'h0,        5'd0,  32'h0,        1'b1, 5'd4, 1'b0, 5'd9,  5'd4,  32'h22222222, 32'h0,        32'h22222222, 32'h0,        2'b00, 2'b00, 32'h0,        1'b0};
        tv[14] = '{2'b00, 5'd0, 32'h0,        5'd0,  32'h0,        1'b0, 5'd0, 1'b1, 5'd4,  5'd9,  32'h0,        32'h22222222, 32'h0,        32'h22222222, 2'b01, 2'b01, 32'h00000010, 1'b0};
        tv[15] = '{2'b00, 5'd0, 32'h0,        5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 5'd4,  5'd9,  32'h0,        32'h22222222, 32'h0,        32'h22222222, 2'b00, 2'b00, 32'h0,        1'b0};
        tv[16] = '{2'b00, 5'd0, 32'h0,        5'd0,  32'h0,        1'b1, 5'd0, 1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        2'b00, 2'b00, 32'h0,        1'b0};
        tv[17] = '{2'b00, 5'd0, 32'h0,        5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 2'b00, 2'b00, 32'h0,        1'b0};
        tv[18] = '{2'b00, 5'd0, 32'h0,        5'd0,  32'h0,        1'b1, 5'd6, 1'b1, 5'd6,  5'd6,  32'h0,        32'h0,        32'h0,        32'h0,        2'b00, 2'b00, 32'h0,        1'b0};
        tv[19] = '{2'b00, 5'd0, 32'h0,        5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 5'd6,  5'd5,  32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 2'b00, 2'b00, 32'h0,        1'b0};

        // Reset held: every output idle regardless of address
        reset = 1'b0;
        idle(5'd5, 5'd31);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rd0_b",   rd_data_b[31:0],  32'h0);
        chk("rst_rd1_b",   rd_data_b[63:32], 32'h0);
        chk("rst_rd0_n",   rd_data_n[31:0],  32'h0);
        chk("rst_busy_b",  busy_vec_b,       32'h0);
        chk("rst_rdbusy",  {30'h0, rd_busy_b}, 32'h0);
        chk("rst_conf_b",  {31'h0, conf_b},  32'h0);
        reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(tv[i]);
            #1;
            chk($sformatf("v%0d_rd0_b", i),   rd_data_b[31:0],      tv[i].e0);
            chk($sformatf("v%0d_rd1_b", i),   rd_data_b[63:32],     tv[i].e1);
            chk($sformatf("v%0d_rd0_n", i),   rd_data_n[31:0],      tv[i].n0);
            chk($sformatf("v%0d_rd1_n", i),   rd_data_n[63:32],     tv[i].n1);
            chk($sformatf("v%0d_rdbusy_b", i), {30'h0, rd_busy_b},  {30'h0, tv[i].eb});
            chk($sformatf("v%0d_rdbusy_n", i), {30'h0, rd_busy_n},  {30'h0, tv[i].nb});
            chk($sformatf("v%0d_busyvec_b", i), busy_vec_b,         tv[i].ebv);
            chk($sformatf("v%0d_busyvec_n", i), busy_vec_n,         tv[i].ebv);
            chk($sformatf("v%0d_conf_b", i),  {31'h0, conf_b},      {31'h0, tv[i].ec});
            chk($sformatf("v%0d_conf_n", i),  {31'h0, conf_n},      {31'h0, tv[i].ec});
        end

        // Build state with a pending producer and a live conflict pulse
        @(negedge clk);
        wr_en = 2'b11; wr_addr = {5'd12, 5'd12}; wr_data = {32'h2, 32'h1};
        alloc_en = 1'b1; alloc_addr = 5'd9; flush = 1'b0; rd_addr = {5'd12, 5'd5};
        @(negedge clk);
        idle(5'd5, 5'd12);
        #1;
        chk("pre_rd0",     rd_data_b[31:0],  32'hDEADBEEF);
        chk("pre_rd1",     rd_data_b[63:32], 32'h00000002);
        chk("pre_busyvec", busy_vec_b,       32'h00000200);
        chk("pre_conf",    {31'h0, conf_b},  32'h1);

        // Asynchronous reset pulse while the clock is low
        #1 reset = 1'b0;
        #1;
        chk("mid_rd0_b",   rd_data_b[31:0],  32'h0);
        chk("mid_rd1_b",   rd_data_b[63:32], 32'h0);
        chk("mid_rd0_n",   rd_data_n[31:0],  32'h0);
        chk("mid_busy_b",  busy_vec_b,       32'h0);
        chk("mid_busy_n",  busy_vec_n,       32'h0);
        chk("mid_conf_b",  {31'h0, conf_b},  32'h0);
        reset = 1'b1;
        @(negedge clk);
        rd_addr = {5'd9, 5'd5};
        #1;
        chk("post_rd0",    rd_data_b[31:0],  32'h0);
        chk("post_rdbusy", {30'h0, rd_busy_b}, 32'h0);
        chk("post_busy",   busy_vec_b,       32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
